// File: rtl/memory_router_pkg.sv
// Shared definitions for the memory router and its region decoder.
// FSM encodings, wait-field width and fault data default.
package memory_router_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int WAIT_W = 4;
    localparam int IDX_W = 3;
    localparam logic [31:0] FAULT_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/region_decoder.sv
// Combinational base/mask region decode with lowest-index priority.
// Produces hit flag, winning region index and in-region offset.
module region_decoder
    import memory_router_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] offset
);

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        offset = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W])
                == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
                offset = addr & ~REGION_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/memory_router.sv
// Routes one CPU request port to NUM_REGIONS targets with wait states,
// single-cycle responses and a fault log for unmapped/misaligned accesses.
module memory_router
    import memory_router_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
        {4{32'hF000_0000}},
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = '0,
    parameter logic [DATA_W-1:0] FAULT_DATA = DATA_W'(FAULT_DATA_DEF)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          req_write,
    input  logic [DATA_W-1:0]             req_wdata,
    output logic                          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_fault,
    output logic [NUM_REGIONS-1:0]        tgt_sel,
    output logic [ADDR_W-1:0]             tgt_addr,
    output logic [NUM_REGIONS-1:0]        tgt_write_en,
    output logic [DATA_W-1:0]             tgt_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rdata,
    input  logic                          fault_clear,
    output logic [ADDR_W-1:0]             fault_addr,
    output logic [7:0]                    fault_count
);

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [ADDR_W-1:0] dec_off;
    logic              aligned;
    logic              accept;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [WAIT_W-1:0] cnt;
    logic              wr;

    region_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_dec (
        .addr   (req_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_off)
    );

    assign aligned = (req_addr[1:0] == 2'b00);
    assign accept = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            req_ready <= 1'b1;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            tgt_sel <= '0;
            tgt_write_en <= '0;
            tgt_addr <= '0;
            tgt_wdata <= '0;
            fault_addr <= '0;
            fault_count <= '0;
            idx <= '0;
            cnt <= '0;
            wr <= 1'b0;
        end else begin
            tgt_write_en <= '0;
            resp_valid <= 1'b0;
            if (fault_clear) begin
                fault_count <= '0;
                fault_addr <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        wr <= req_write;
                        tgt_wdata <= req_wdata;
                        if (dec_hit && aligned) begin
                            state <= ACCESS;
                            idx <= dec_idx;
                            tgt_sel <= NUM_REGIONS'(1) << dec_idx;
                            tgt_addr <= dec_off;
                            cnt <= REGION_WAIT[32'(dec_idx)*WAIT_W +: WAIT_W];
                            if (req_write) begin
                                tgt_write_en <= NUM_REGIONS'(1) << dec_idx;
                            end
                        end else begin
                            state <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= FAULT_DATA;
                            // A fault in the clearing cycle starts a fresh log.
                            if (fault_clear || fault_count == 8'd0) begin
                                fault_count <= 8'd1;
                                fault_addr <= req_addr;
                            end else if (fault_count != 8'hFF) begin
                                fault_count <= fault_count + 8'd1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        tgt_sel <= '0;
                        resp_rdata <= wr ? '0
                            : tgt_rdata[32'(idx)*DATA_W +: DATA_W];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    req_ready <= 1'b1;
                    resp_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_router.sv
// Directed self-checking bench for memory_router.
// Each task drives one scenario and checks its own hand-computed results.
module tb_memory_router;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_write;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         resp_fault;
    logic [3:0]   tgt_sel;
    logic [31:0]  tgt_addr;
    logic [3:0]   tgt_write_en;
    logic [31:0]  tgt_wdata;
    logic [127:0] tgt_rdata;
    logic         fault_clear;
    logic [31:0]  fault_addr;
    logic [7:0]   fault_count;

    int n_run = 0;
    int n_fail = 0;

    // r0: 0x0xxx_xxxx W=5, r1: 0x1xxx_xxxx W=0,
    // r2: 0x2xxx_xxxx W=3, r3: 0x0000_0xxx W=1 (overlaps r0)
    memory_router #(
        .NUM_REGIONS (4),
        .ADDR_W      (32),
        .DATA_W      (32),
        .REGION_BASE ({32'h0000_0000, 32'h2000_0000,
                       32'h1000_0000, 32'h0000_0000}),
        .REGION_MASK ({32'hFFFF_F000, 32'hF000_0000,
                       32'hF000_0000, 32'hF000_0000}),
        .REGION_WAIT ({4'd1, 4'd3, 4'd0, 4'd5}),
        .FAULT_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .tgt_sel      (tgt_sel),
        .tgt_addr     (tgt_addr),
        .tgt_write_en (tgt_write_en),
        .tgt_wdata    (tgt_wdata),
        .tgt_rdata    (tgt_rdata),
        .fault_clear  (fault_clear),
        .fault_addr   (fault_addr),
        .fault_count  (fault_count)
    );

    always #5 clk = ~clk;

    // One request; lat = 1 means resp_valid seen just after the accept edge.
    task automatic run_req(
        input  logic [31:0] a,
        input  logic        w,
        input  logic [31:0] d,
        input  logic        clr,
        output int          lat,
        output int          we_n,
        output int          we_at,
        output logic [3:0]  we_v,
        output logic [3:0]  sel1,
        output logic [31:0] addr1,
        output logic [31:0] rdata,
        output logic        flt,
        output logic        rdy_resp
    );
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = a;
        req_write = w;
        req_wdata = d;
        fault_clear = clr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        fault_clear = 1'b0;
        sel1 = tgt_sel;
        addr1 = tgt_addr;
        lat = 0;
        we_n = 0;
        we_at = 0;
        we_v = '0;
        do begin
            if (lat != 0) begin
                @(posedge clk);
                #1;
            end
            lat++;
            if (tgt_write_en != 4'b0) begin
                we_n++;
                if (we_at == 0) begin
                    we_at = lat;
                    we_v = tgt_write_en;
                end
            end
        end while (!resp_valid && lat < 30);
        rdata = resp_rdata;
        flt = resp_fault;
        rdy_resp = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_write = 1'b0;
        req_wdata = '0;
        fault_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_run++;
        if ({req_ready, resp_valid, resp_fault} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 100",
                     {req_ready, resp_valid, resp_fault});
        end
        n_run++;
        if ({tgt_sel, tgt_write_en} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tgt: got %h want 00", {tgt_sel, tgt_write_en});
        end
        n_run++;
        if ({resp_rdata, tgt_addr, tgt_wdata, fault_addr} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0",
                     {resp_rdata, tgt_addr, tgt_wdata, fault_addr});
        end
        n_run++;
        if (fault_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", fault_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_read_hit();
        int lat, we_n, we_at;
        logic [3:0] we_v, sel1;
        logic [31:0] a1, rd;
        logic flt, rr;
        run_req(32'h1000_0000, 1'b0, 32'h0, 1'b0,
                lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
        n_run++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL rd_latency: got %0d want 2", lat);
        end
        n_run++;
        if (rd !== 32'hCAFE_0001 || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data: got %h/%b want cafe0001/0", rd, flt);
        end
        n_run++;
        if (sel1 !== 4'b0010 || a1 !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_sel: got %b/%h want 0010/0", sel1, a1);
        end
        n_run++;
        if (we_n !== 0) begin
            n_fail++;
            $display("FAIL rd_no_we: got %0d pulses want 0", we_n);
        end
        run_req(32'h1ABC_0010, 1'b0, 32'h0, 1'b0,
                lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
        n_run++;
        if (a1 !== 32'h0ABC_0010 || rd !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL rd_offset: got %h/%h want 0abc0010/cafe0001", a1, rd);
        end
    endtask

    task automatic test_write_wait();
        int lat, we_n, we_at;
        logic [3:0] we_v, sel1;
        logic [31:0] a1, rd;
        logic flt, rr;
        run_req(32'h2000_0004, 1'b1, 32'h1234_5678, 1'b0,
                lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
        n_run++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d want 5", lat);
        end
        n_run++;
        if (we_n !== 1 || we_at !== 1 || we_v !== 4'b0100) begin
            n_fail++;
            $display("FAIL wr_strobe: got n=%0d at=%0d v=%b want 1/1/0100",
                     we_n, we_at, we_v);
        end
        n_run++;
        if (rd !== 32'h0 || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack: got %h/%b want 0/0", rd, flt);
        end
        n_run++;
        if (tgt_wdata !== 32'h1234_5678 || a1 !== 32'h4 || sel1 !== 4'b0100) begin
            n_fail++;
            $display("FAIL wr_tgt: got %h/%h/%b want 12345678/4/0100",
                     tgt_wdata, a1, sel1);
        end
    endtask

    task automatic test_fault();
        int lat, we_n, we_at;
        logic [3:0] we_v, sel1;
        logic [31:0] a1, rd;
        logic flt, rr;
        run_req(32'hF000_0000, 1'b0, 32'h0, 1'b0,
                lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
        n_run++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL flt_latency: got %0d want 1", lat);
        end
        n_run++;
        if (rd !== 32'hDEAD_BEEF || flt !== 1'b1) begin
            n_fail++;
            $display("FAIL flt_resp: got %h/%b want deadbeef/1", rd, flt);
        end
        n_run++;
        if (fault_addr !== 32'hF000_0000 || fault_count !== 8'd1) begin
            n_fail++;
            $display("FAIL flt_log: got %h/%0d want f0000000/1",
                     fault_addr, fault_count);
        end
        n_run++;
        if (sel1 !== 4'b0 || we_n !== 0) begin
            n_fail++;
            $display("FAIL flt_no_tgt: got sel %b we %0d want 0/0", sel1, we_n);
        end
    endtask

    task automatic test_back_to_back();
        int lat, we_n, we_at;
        logic [3:0] we_v, sel1;
        logic [31:0] a1, rd;
        logic flt, rr;
        run_req(32'hE000_0000, 1'b1, 32'h5, 1'b0,
                lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
        n_run++;
        if (rr !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got resp=%b after=%b want 0/1",
                     rr, req_ready);
        end
        n_run++;
        if (fault_count !== 8'd2 || fault_addr !== 32'hF000_0000) begin
            n_fail++;
            $display("FAIL b2b_log: got %0d/%h want 2/f0000000",
                     fault_count, fault_addr);
        end
    endtask

    task automatic test_overlap();
        int lat, we_n, we_at;
        logic [3:0] we_v, sel1;
        logic [31:0] a1, rd;
        logic flt, rr;
        run_req(32'h0000_0040, 1'b0, 32'h0, 1'b0,
                lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
        n_run++;
        if (sel1 !== 4'b0001 || a1 !== 32'h40) begin
            n_fail++;
            $display("FAIL ovl_sel: got %b/%h want 0001/40", sel1, a1);
        end
        n_run++;
        if (lat !== 7 || rd !== 32'hCAFE_0000) begin
            n_fail++;
            $display("FAIL ovl_resp: got %0d/%h want 7/cafe0000", lat, rd);
        end
    endtask

    task automatic test_saturate();
        int lat, we_n, we_at;
        logic [3:0] we_v, sel1;
        logic [31:0] a1, rd;
        logic flt, rr;
        @(negedge clk);
        fault_clear = 1'b1;
        @(posedge clk);
        #1;
        fault_clear = 1'b0;
        n_run++;
        if (fault_count !== 8'd0 || fault_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL clr: got %0d/%h want 0/0", fault_count, fault_addr);
        end
        for (int i = 0; i < 256; i++) begin
            run_req(32'h1000_0001 + (i << 4), 1'b0, 32'h0, 1'b0,
                    lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
            if (i == 0) begin
                n_run++;
                if (lat !== 1 || flt !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL misalign: got %0d/%b/%h want 1/1/deadbeef",
                             lat, flt, rd);
                end
            end
        end
        n_run++;
        if (fault_count !== 8'd255 || fault_addr !== 32'h1000_0001) begin
            n_fail++;
            $display("FAIL sat: got %0d/%h want 255/10000001",
                     fault_count, fault_addr);
        end
        run_req(32'h2000_0002, 1'b0, 32'h0, 1'b1,
                lat, we_n, we_at, we_v, sel1, a1, rd, flt, rr);
        n_run++;
        if (fault_count !== 8'd1 || fault_addr !== 32'h2000_0002) begin
            n_fail++;
            $display("FAIL clr_fault: got %0d/%h want 1/20000002",
                     fault_count, fault_addr);
        end
    endtask

    task automatic test_reset_mid();
        int rv = 0;
        int we = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = 32'h0000_0100;
        req_write = 1'b1;
        req_wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_run++;
        if (tgt_write_en !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_pre_we: got %b want 0001", tgt_write_en);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n_run++;
        if (req_ready !== 1'b1 || tgt_sel !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_abort: got rdy %b sel %b want 1/0000",
                     req_ready, tgt_sel);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) rv++;
            if (tgt_write_en != 4'b0) we++;
        end
        n_run++;
        if (rv !== 0 || we !== 0) begin
            n_fail++;
            $display("FAIL rst_quiet: got resp %0d we %0d want 0/0", rv, we);
        end
        n_run++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready: got %b want 1", req_ready);
        end
    endtask

    initial begin
        tgt_rdata = {32'hCAFE_0003, 32'hCAFE_0002,
                     32'hCAFE_0001, 32'hCAFE_0000};
        test_reset();
        test_read_hit();
        test_write_wait();
        test_fault();
        test_back_to_back();
        test_overlap();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
